// File: rtl/register_bank.sv
// Multi-entry register file with load/inc/dec/clear write ops, two combinational
// read ports with optional same-cycle bypass, and registered carry/zero flags.
module register_bank #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              carry,
  output logic              zero
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  generate
    if (ADDR_W != $clog2(DEPTH)) begin : g_addr_check
      $error("register_bank: ADDR_W must equal log2(DEPTH)");
    end
  endgenerate

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] next_val;
  logic             carry_n;

  // Result of the requested op on the addressed entry; shared by the write path and bypass.
  always_comb begin
    cur_val  = regs_q[waddr];
    next_val = '0;
    carry_n  = 1'b0;
    case (op)
      OP_LOAD:  next_val = wdata;
      OP_INC:   {carry_n, next_val} = {1'b0, cur_val} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin
        next_val = cur_val - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_n  = (cur_val == '0);
      end
      OP_CLEAR: next_val = '0;
      default:  next_val = '0;
    endcase
  end

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (we) begin
      regs_d[waddr] = next_val;
      carry_d       = carry_n;
      zero_d        = (next_val == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Bypass is suppressed during reset so reads show the cleared storage.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if ((BYPASS != 0) && we && !reset) begin
      if (raddr_a == waddr) rdata_a = next_val;
      if (raddr_b == waddr) rdata_b = next_val;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
Parametrised multi-register storage for the pipelined CPU datapath. It is the successor to the single load-enable register, generalised to DEPTH entries of WIDTH bits. It has one write port with an op mode (load / increment / decrement / clear), two combinational read ports with optional write-bypass, and registered carry and zero flags. It sits between the decode/execute stage and the ALU operand muxes.

Parameters:
WIDTH, 4, data width of each register (2..16)
DEPTH, 4, number of registers; power of two, 2..16
ADDR_W, 2, address width; must equal log2(DEPTH); instantiation with a mismatch is illegal (simulation $error at time 0)
BYPASS, 1, 1 = read ports return the value being written this cycle; 0 = read ports return stored value only

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
we  input  1  write/op enable for the addressed register
op  input  2  00 LOAD, 01 INC, 10 DEC, 11 CLEAR
waddr  input  ADDR_W  target register for op
wdata  input  WIDTH  data for LOAD (ignored for other ops)
raddr_a  input  ADDR_W  read port A address
rdata_a  output  WIDTH  read port A data
raddr_b  input  ADDR_W  read port B address
rdata_b  output  WIDTH  read port B data
carry  output  1  registered carry/borrow flag of last executed op
zero  output  1  registered flag: result of last executed op == 0

Behaviour:
- Reset is asserted asynchronously. All registers go to 0, carry = 0, zero = 0, immediately on reset assertion, independent of clock.
- While reset is high, writes are ignored. Reset coinciding with a clock edge where we=1 leaves everything at reset values.
- First write is accepted on the first rising edge after reset deasserts.
- When we=0 on a rising edge, all registers and both flags hold their values.
- When we=1 on a rising edge, only reg[waddr] updates, with new value N:
  - LOAD: N = wdata; carry <= 0.
  - INC: N = reg+1 mod 2^WIDTH; carry <= 1 iff reg was all ones (wrap to 0), else 0.
  - DEC: N = reg-1 mod 2^WIDTH; carry <= 1 iff reg was 0 (wrap to all ones, borrow), else 0.
  - CLEAR: N = 0; carry <= 0.
  - zero <= (N == 0) for every op.
- Latency: the result is visible in storage one cycle after the edge. Flags update on the same edge as the register.
- Read ports are combinational, 0-cycle: rdata_x = reg[raddr_x].
- BYPASS=1: if we=1 and raddr_x == waddr, rdata_x = N, the same-cycle computed next value, for all four ops. This applies to each port independently, and to both ports at once when both addresses match.
- BYPASS=0: rdata_x = stored value; the new value appears the cycle after the edge.
- While reset is high, rdata_x reflects the reset storage (0), with no bypass.
- raddr_a == raddr_b is legal; both ports return identical data.
- No X propagation: op is fully decoded, so no illegal op exists.
- Storage is flops only, no latches. No read-side state.

Test Plan:
- Reset: drive reset=1 mid-cycle with reg[1]=4'h9 -> rdata for addr 1 is 0 and carry=0, zero=0 before the next clock edge. Deassert reset, then LOAD 4'hA to addr 2 -> rdata(2)=4'hA after the edge, zero=0.
- INC wrap (WIDTH=4): LOAD 4'hF to addr 3, then INC addr 3 -> reg[3]=0, carry=1, zero=1. INC again -> reg[3]=1, carry=0, zero=0.
- DEC borrow: CLEAR addr 0 (zero=1, carry=0), then DEC addr 0 -> reg[0]=4'hF, carry=1, zero=0.
- Bypass: BYPASS=1, reg[1]=5, we=1 op=INC waddr=1, raddr_a=raddr_b=1 -> both rdata show 6 in the same cycle. Repeat with BYPASS=0 -> both show 5 until after the edge, then 6.
- Hold/isolation: LOAD distinct values to all DEPTH registers, then 10 cycles with we=0 and random wdata/op -> all registers and flags unchanged. One INC to addr 2 -> only reg[2] changes.
- Reset wins: assert reset in the same cycle as we=1 LOAD 4'h7 to addr 0 -> reg[0]=0, flags 0. Parameter sweep WIDTH=8, DEPTH=16: INC 8'hFF -> 0 with carry=1.
